// File: rtl/triangle_setup_unit.sv
// Triangle setup front end: bounding box, edge functions, culling, winding
// normalisation and an iterative area reciprocal, buffered in a FWFT FIFO.
module triangle_setup_unit #(
    parameter int DATAWIDTH    = 12,
    parameter int ACCWIDTH     = 25,
    parameter int RECIP_WIDTH  = 16,
    parameter int FIFO_DEPTH   = 2,
    parameter int SCREEN_MIN_X = 0,
    parameter int SCREEN_MAX_X = 320,
    parameter int SCREEN_MIN_Y = 0,
    parameter int SCREEN_MAX_Y = 320
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [1:0]                    i_cull_mode,
    output logic                          i_ready,
    input  logic                          i_triangle_dv,
    input  logic [2*DATAWIDTH-1:0]        i_v0,
    input  logic [2*DATAWIDTH-1:0]        i_v1,
    input  logic [2*DATAWIDTH-1:0]        i_v2,
    input  logic                          o_ready,
    output logic                          o_valid,
    output logic [2*DATAWIDTH-1:0]        bb_tl,
    output logic [2*DATAWIDTH-1:0]        bb_br,
    output logic signed [ACCWIDTH-1:0]    edge_val0,
    output logic signed [ACCWIDTH-1:0]    edge_val1,
    output logic signed [ACCWIDTH-1:0]    edge_val2,
    output logic [2*DATAWIDTH+1:0]        edge_delta0,
    output logic [2*DATAWIDTH+1:0]        edge_delta1,
    output logic [2*DATAWIDTH+1:0]        edge_delta2,
    output logic [ACCWIDTH-1:0]           area,
    output logic [RECIP_WIDTH-1:0]        area_inv,
    output logic                          o_ccw,
    output logic [15:0]                   culled_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int DCW   = $clog2(RECIP_WIDTH + 1);

    typedef logic signed [DATAWIDTH-1:0] coord_t;
    typedef logic signed [DATAWIDTH:0]   delta_t;
    typedef logic signed [ACCWIDTH-1:0]  acc_t;

    localparam coord_t SMIN_X = coord_t'(SCREEN_MIN_X);
    localparam coord_t SMAX_X = coord_t'(SCREEN_MAX_X);
    localparam coord_t SMIN_Y = coord_t'(SCREEN_MIN_Y);
    localparam coord_t SMAX_Y = coord_t'(SCREEN_MAX_Y);

    typedef enum logic [2:0] {IDLE, SETUP, CULL, DIVIDE, PUSH} state_t;

    typedef struct packed {
        logic [2*DATAWIDTH-1:0]       tl;
        logic [2*DATAWIDTH-1:0]       br;
        logic [2:0][ACCWIDTH-1:0]     ev;
        logic [2:0][2*DATAWIDTH+1:0]  d;
        logic [ACCWIDTH-1:0]          ar;
        logic [RECIP_WIDTH-1:0]       inv;
        logic                         ccw;
    } entry_t;

    function automatic delta_t diff(input coord_t a, input coord_t b);
        return {a[DATAWIDTH-1], a} - {b[DATAWIDTH-1], b};
    endfunction

    function automatic acc_t sext(input delta_t d);
        return {{(ACCWIDTH-DATAWIDTH-1){d[DATAWIDTH]}}, d};
    endfunction

    function automatic acc_t edge_fn(input coord_t ax, input coord_t ay, input coord_t bx,
                                     input coord_t by, input coord_t px, input coord_t py);
        return sext(diff(px, ax)) * sext(diff(by, ay)) - sext(diff(py, ay)) * sext(diff(bx, ax));
    endfunction

    function automatic coord_t min2(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t max2(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic int nxt(input int i);
        return (i == 2) ? 0 : i + 1;
    endfunction

    function automatic logic [RECIP_WIDTH-1:0] sat_recip(input logic [RECIP_WIDTH:0] q);
        return q[RECIP_WIDTH] ? '1 : q[RECIP_WIDTH-1:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    state_t state, next_state;

    coord_t     vx_p0 [3];
    coord_t     vy_p0 [3];
    logic [1:0] mode_p0;

    coord_t min_x, max_x, min_y, max_y;
    coord_t tl_x_s, tl_y_s, br_x_s, br_y_s;
    logic   box_ok_s;
    acc_t   ev_s [3];
    delta_t dx_s [3];
    delta_t dy_s [3];
    acc_t   area_s;

    coord_t tl_x_p1, tl_y_p1, br_x_p1, br_y_p1;
    logic   box_ok_p1;
    acc_t   ev_p1 [3];
    delta_t dx_p1 [3];
    delta_t dy_p1 [3];
    acc_t   area_p1;

    acc_t                ev_p2 [3];
    delta_t              dx_p2 [3];
    delta_t              dy_p2 [3];
    logic [ACCWIDTH-1:0] area_p2;
    logic                ccw_p2;

    logic [ACCWIDTH:0]    rem;
    logic [ACCWIDTH:0]    shifted;
    logic [ACCWIDTH:0]    rem_next;
    logic                 q_bit;
    logic [RECIP_WIDTH:0] quo;
    logic [DCW-1:0]       div_cnt;

    entry_t           mem [FIFO_DEPTH];
    entry_t           push_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, push, pop, drop;

    // Stage p0 -> p1: box and edge setup from captured vertices
    always_comb begin
        min_x    = min2(min2(vx_p0[0], vx_p0[1]), vx_p0[2]);
        max_x    = max2(max2(vx_p0[0], vx_p0[1]), vx_p0[2]);
        min_y    = min2(min2(vy_p0[0], vy_p0[1]), vy_p0[2]);
        max_y    = max2(max2(vy_p0[0], vy_p0[1]), vy_p0[2]);
        tl_x_s   = max2(min_x, SMIN_X);
        tl_y_s   = max2(min_y, SMIN_Y);
        br_x_s   = min2(max_x, SMAX_X);
        br_y_s   = min2(max_y, SMAX_Y);
        box_ok_s = !(max_x < SMIN_X || min_x > SMAX_X || max_y < SMIN_Y || min_y > SMAX_Y);
        for (int i = 0; i < 3; i++) begin
            ev_s[i] = edge_fn(vx_p0[i], vy_p0[i], vx_p0[nxt(i)], vy_p0[nxt(i)], tl_x_s, tl_y_s);
            dx_s[i] = diff(vy_p0[nxt(i)], vy_p0[i]);
            dy_s[i] = diff(vx_p0[i], vx_p0[nxt(i)]);
        end
        area_s = edge_fn(vx_p0[0], vy_p0[0], vx_p0[1], vy_p0[1], vx_p0[2], vy_p0[2]);
    end

    assign drop = (area_p1 == '0) || !box_ok_p1 ||
                  (mode_p0 == 2'd1 && area_p1 < 0) ||
                  (mode_p0 == 2'd2 && area_p1 > 0);

    // One restoring-division step; the dividend 2^RECIP_WIDTH contributes a single 1 on the first step
    always_comb begin
        shifted  = {rem[ACCWIDTH-1:0], div_cnt == DCW'(RECIP_WIDTH)};
        q_bit    = shifted >= {1'b0, area_p2};
        rem_next = q_bit ? shifted - {1'b0, area_p2} : shifted;
    end

    always_ff @(posedge clk) begin
        if (i_ready && i_triangle_dv) begin
            vx_p0[0] <= i_v0[2*DATAWIDTH-1:DATAWIDTH];
            vy_p0[0] <= i_v0[DATAWIDTH-1:0];
            vx_p0[1] <= i_v1[2*DATAWIDTH-1:DATAWIDTH];
            vy_p0[1] <= i_v1[DATAWIDTH-1:0];
            vx_p0[2] <= i_v2[2*DATAWIDTH-1:DATAWIDTH];
            vy_p0[2] <= i_v2[DATAWIDTH-1:0];
            mode_p0  <= i_cull_mode;
        end
        if (state == SETUP) begin
            tl_x_p1   <= tl_x_s;
            tl_y_p1   <= tl_y_s;
            br_x_p1   <= br_x_s;
            br_y_p1   <= br_y_s;
            box_ok_p1 <= box_ok_s;
            ev_p1     <= ev_s;
            dx_p1     <= dx_s;
            dy_p1     <= dy_s;
            area_p1   <= area_s;
        end
        // Stage p1 -> p2: winding normalisation so inside is always all E >= 0
        if (state == CULL) begin
            for (int i = 0; i < 3; i++) begin
                ev_p2[i] <= (area_p1 < 0) ? -ev_p1[i] : ev_p1[i];
                dx_p2[i] <= (area_p1 < 0) ? -dx_p1[i] : dx_p1[i];
                dy_p2[i] <= (area_p1 < 0) ? -dy_p1[i] : dy_p1[i];
            end
            area_p2 <= (area_p1 < 0) ? -area_p1 : area_p1;
            ccw_p2  <= area_p1 < 0;
            rem     <= '0;
            quo     <= '0;
            div_cnt <= DCW'(RECIP_WIDTH);
        end
        if (state == DIVIDE) begin
            rem     <= rem_next;
            quo     <= {quo[RECIP_WIDTH-1:0], q_bit};
            div_cnt <= div_cnt - DCW'(1);
        end
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        push_entry.tl  = {tl_x_p1, tl_y_p1};
        push_entry.br  = {br_x_p1, br_y_p1};
        for (int i = 0; i < 3; i++) begin
            push_entry.ev[i] = ev_p2[i];
            push_entry.d[i]  = {dx_p2[i], dy_p2[i]};
        end
        push_entry.ar  = area_p2;
        push_entry.inv = sat_recip(quo);
        push_entry.ccw = ccw_p2;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        i_ready    = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_triangle_dv)
                    next_state = SETUP;
            end
            SETUP:  next_state = CULL;
            CULL:   next_state = drop ? IDLE : DIVIDE;
            DIVIDE: if (div_cnt == '0) next_state = PUSH;
            PUSH: begin
                if (!full || pop) begin
                    push       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign full    = count == CNT_W'(FIFO_DEPTH);
    assign o_valid = count != '0;
    assign pop     = o_valid && o_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            culled_count <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (state == CULL && drop)
                culled_count <= sat_inc16(culled_count);
        end
    end

    // FIFO head is shown only while valid so stale storage never leaks after reset
    assign head        = mem[rd_ptr];
    assign bb_tl       = o_valid ? head.tl    : '0;
    assign bb_br       = o_valid ? head.br    : '0;
    assign edge_val0   = o_valid ? head.ev[0] : '0;
    assign edge_val1   = o_valid ? head.ev[1] : '0;
    assign edge_val2   = o_valid ? head.ev[2] : '0;
    assign edge_delta0 = o_valid ? head.d[0]  : '0;
    assign edge_delta1 = o_valid ? head.d[1]  : '0;
    assign edge_delta2 = o_valid ? head.d[2]  : '0;
    assign area        = o_valid ? head.ar    : '0;
    assign area_inv    = o_valid ? head.inv   : '0;
    assign o_ccw       = o_valid ? head.ccw   : 1'b0;

endmodule

// File: tb/tb_triangle_setup_unit.sv
// Directed bench for triangle_setup_unit: vector table plus FIFO stall and
// mid-divide reset sequences.
`timescale 1ns/1ps
module tb_triangle_setup_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  cull_mode;
    logic        i_ready;
    logic        dv;
    logic [23:0] v0, v1, v2;
    logic        o_ready;
    logic        o_valid;
    logic [23:0] bb_tl, bb_br;
    logic signed [24:0] edge_val0, edge_val1, edge_val2;
    logic [25:0] edge_delta0, edge_delta1, edge_delta2;
    logic [24:0] area;
    logic [15:0] area_inv;
    logic        o_ccw;
    logic [15:0] culled_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_culled = 0;

    typedef struct {
        logic [23:0] a, b, c;
        logic [1:0]  m;
        bit          kept;
        logic [23:0] tl, br;
        int          e0, e1, e2;
        logic [25:0] d0, d1, d2;
        int          ar, inv;
        bit          ccw;
    } vec_t;

    vec_t vecs [9];

    triangle_setup_unit dut (
        .clk(clk), .rstn(rstn), .i_cull_mode(cull_mode), .i_ready(i_ready),
        .i_triangle_dv(dv), .i_v0(v0), .i_v1(v1), .i_v2(v2),
        .o_ready(o_ready), .o_valid(o_valid), .bb_tl(bb_tl), .bb_br(bb_br),
        .edge_val0(edge_val0), .edge_val1(edge_val1), .edge_val2(edge_val2),
        .edge_delta0(edge_delta0), .edge_delta1(edge_delta1), .edge_delta2(edge_delta2),
        .area(area), .area_inv(area_inv), .o_ccw(o_ccw), .culled_count(culled_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [23:0] pt(input int x, input int y);
        logic [11:0] xs, ys;
        xs = x[11:0];
        ys = y[11:0];
        return {xs, ys};
    endfunction

    function automatic logic [25:0] d2(input int dx, input int dy);
        logic [12:0] xs, ys;
        xs = dx[12:0];
        ys = dy[12:0];
        return {xs, ys};
    endfunction

    function automatic vec_t mk(input logic [23:0] a, b, c, input logic [1:0] m, input bit kept,
                                input logic [23:0] tl, br, input int e0, e1, e2,
                                input logic [25:0] dd0, dd1, dd2, input int ar, inv, input bit ccw);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.m = m; v.kept = kept;
        v.tl = tl; v.br = br; v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.d0 = dd0; v.d1 = dd1; v.d2 = dd2; v.ar = ar; v.inv = inv; v.ccw = ccw;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] a, b, c, input logic [1:0] m);
        int w = 0;
        while (!i_ready && w < 80) begin
            tick();
            w++;
        end
        check("send_ready", i_ready, 1);
        v0 = a; v1 = b; v2 = c; cull_mode = m; dv = 1'b1;
        tick();
        dv = 1'b0;
        cull_mode = ~m;
    endtask

    task automatic check_out(input string p, input vec_t v);
        check({p, "_bb_tl"}, bb_tl, v.tl);
        check({p, "_bb_br"}, bb_br, v.br);
        check({p, "_ev0"}, edge_val0, v.e0);
        check({p, "_ev1"}, edge_val1, v.e1);
        check({p, "_ev2"}, edge_val2, v.e2);
        check({p, "_d0"}, edge_delta0, v.d0);
        check({p, "_d1"}, edge_delta1, v.d1);
        check({p, "_d2"}, edge_delta2, v.d2);
        check({p, "_area"}, area, v.ar);
        check({p, "_inv"}, area_inv, v.inv);
        check({p, "_ccw"}, o_ccw, v.ccw);
    endtask

    task automatic pop_one();
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
    endtask

    task automatic run_vec(input string p, input vec_t v);
        int  cyc;
        bit  seen;
        send(v.a, v.b, v.c, v.m);
        cyc = 1;
        if (v.kept) begin
            while (!o_valid && cyc < 60) begin
                tick();
                cyc++;
            end
            check({p, "_latency"}, cyc, 21);
            check_out(p, v);
            pop_one();
            check({p, "_popped"}, o_valid, 0);
        end else begin
            tick();
            check({p, "_cull_busy"}, i_ready, 0);
            tick();
            exp_culled++;
            check({p, "_cull_ready"}, i_ready, 1);
            check({p, "_culled_count"}, culled_count, exp_culled);
            seen = 1'b0;
            for (int i = 0; i < 25; i++) begin
                tick();
                if (o_valid) seen = 1'b1;
            end
            check({p, "_no_output"}, seen, 0);
        end
    endtask

    initial begin
        vecs[0] = mk(pt(10,10), pt(10,20), pt(20,10), 2'd1, 1, pt(10,10), pt(20,20),
                     0, 100, 0, d2(10,0), d2(-10,-10), d2(0,10), 100, 655, 0);
        vecs[1] = mk(pt(10,10), pt(20,10), pt(10,20), 2'd1, 0, '0, '0,
                     0, 0, 0, '0, '0, '0, 0, 0, 0);
        vecs[2] = mk(pt(10,10), pt(20,10), pt(10,20), 2'd0, 1, pt(10,10), pt(20,20),
                     0, 100, 0, d2(0,10), d2(-10,-10), d2(10,0), 100, 655, 1);
        vecs[3] = mk(pt(0,0), pt(0,1), pt(1,0), 2'd3, 1, pt(0,0), pt(1,1),
                     0, 1, 0, d2(1,0), d2(-1,-1), d2(0,1), 1, 65535, 0);
        vecs[4] = mk(pt(0,0), pt(5,5), pt(10,10), 2'd0, 0, '0, '0,
                     0, 0, 0, '0, '0, '0, 0, 0, 0);
        vecs[5] = mk(pt(10,10), pt(10,20), pt(20,10), 2'd2, 0, '0, '0,
                     0, 0, 0, '0, '0, '0, 0, 0, 0);
        vecs[6] = mk(pt(-10,-10), pt(-10,20), pt(20,-10), 2'd0, 1, pt(0,0), pt(20,20),
                     300, 300, 300, d2(30,0), d2(-30,-30), d2(0,30), 900, 72, 0);
        vecs[7] = mk(pt(400,400), pt(400,410), pt(410,400), 2'd0, 0, '0, '0,
                     0, 0, 0, '0, '0, '0, 0, 0, 0);
        vecs[8] = mk(pt(10,10), pt(20,10), pt(10,20), 2'd2, 1, pt(10,10), pt(20,20),
                     0, 100, 0, d2(0,10), d2(-10,-10), d2(10,0), 100, 655, 1);

        rstn = 1'b0; dv = 1'b0; o_ready = 1'b0; cull_mode = 2'd0;
        v0 = '0; v1 = '0; v2 = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("rst_o_valid", o_valid, 0);
        check("rst_i_ready", i_ready, 1);
        check("rst_culled", culled_count, 0);
        check("rst_area", area, 0);
        check("rst_ev0", edge_val0, 0);
        check("rst_ccw", o_ccw, 0);

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Two entries fill the FIFO, the third stalls in PUSH until a pop frees a slot
        o_ready = 1'b0;
        send(vecs[0].a, vecs[0].b, vecs[0].c, 2'd0);
        send(vecs[3].a, vecs[3].b, vecs[3].c, 2'd0);
        send(vecs[6].a, vecs[6].b, vecs[6].c, 2'd0);
        repeat (25) tick();
        check("stall_i_ready", i_ready, 0);
        check("stall_o_valid", o_valid, 1);
        check_out("stall_head0", vecs[0]);
        pop_one();
        check("stall_released", i_ready, 1);
        check_out("stall_head1", vecs[3]);
        pop_one();
        check_out("stall_head2", vecs[6]);
        pop_one();
        check("stall_drained", o_valid, 0);

        // Reset while one result is queued and another is mid-divide
        send(vecs[3].a, vecs[3].b, vecs[3].c, 2'd0);
        repeat (21) tick();
        check("pre_rst_valid", o_valid, 1);
        send(vecs[0].a, vecs[0].b, vecs[0].c, 2'd0);
        repeat (8) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_rst_o_valid", o_valid, 0);
        check("mid_rst_culled", culled_count, 0);
        check("mid_rst_i_ready", i_ready, 1);
        check("mid_rst_area", area, 0);
        exp_culled = 0;
        run_vec("post_rst", vecs[0]);
        run_vec("post_rst_cull", vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
